mem_responder: RTL and testbench



---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 92 +++++++++
 tb/tb_mem_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/acknowledge bundle between the control unit (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          enmem;
    logic          wrmem;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          busy;
    logic [7:0]    ntrans;

    modport master (
        output enmem, wrmem, addr, wdata,
        input  rdata, ready, busy, ntrans
    );

    modport slave (
        input  enmem, wrmem, addr, wdata,
        output rdata, ready, busy, ntrans
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: latches one request, waits WAIT_CYCLES+1 cycles, completes it
// against an internal register array, then pulses ready for one cycle.
module mem_responder #(
    parameter int DW          = 8,
    parameter int AW          = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    mem_responder_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int             DEPTH     = 2 ** AW;
    localparam logic [3:0]     WAIT_INIT = 4'(WAIT_CYCLES);

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          ready_q;
    logic          busy_q;
    logic [7:0]    ntrans_q;
    logic [DW-1:0] mem_q [DEPTH];

    // Request fields are latched at acceptance; bus inputs are ignored until back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            ntrans_q <= '0;
            // NOTE: the array is reset on purpose so reads after reset return 0; this forces flops, not RAM.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.enmem) begin
                        wr_q    <= bus.wrmem;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        cnt_q   <= WAIT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        if (wr_q) begin
                            mem_q[addr_q] <= wdata_q;
                        end else begin
                            rdata_q <= mem_q[addr_q];
                        end
                        ntrans_q <= ntrans_q + 8'd1;
                        ready_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;
    assign bus.ntrans = ntrans_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with zero wait states.
module tb_mem_responder;
    localparam int W_A = 2;
    localparam int W_Z = 0;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_responder_if #(.DW(8), .AW(4)) bus_a ();
    mem_responder_if #(.DW(8), .AW(4)) bus_z ();

    mem_responder #(.DW(8), .AW(4), .WAIT_CYCLES(W_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    mem_responder #(.DW(8), .AW(4), .WAIT_CYCLES(W_Z)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction on the WAIT_CYCLES=2 instance; scramble drives junk on the bus during WAIT.
    task automatic req_a(input logic wr, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input logic scramble, input string tag);
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(bus_a.busy), 32'd0);
        bus_a.enmem = 1'b1;
        bus_a.wrmem = wr;
        bus_a.addr  = a;
        bus_a.wdata = d;
        for (int k = 1; k <= W_A + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (scramble) begin
                    bus_a.wrmem = 1'b1;
                    bus_a.addr  = 4'h7;
                    bus_a.wdata = 8'hFF;
                end else begin
                    bus_a.enmem = 1'b0;
                end
            end
            chk({tag, "_busy"}, 32'(bus_a.busy), 32'd1);
            if (k < W_A + 2) begin
                chk({tag, "_ready_early"}, 32'(bus_a.ready), 32'd0);
            end else begin
                chk({tag, "_ready"}, 32'(bus_a.ready), 32'd1);
                chk({tag, "_rdata"}, 32'(bus_a.rdata), 32'(exp_rd));
                bus_a.enmem = 1'b0;
            end
        end
    endtask

    // One transaction on the WAIT_CYCLES=0 instance: ready in the cycle after N+1.
    task automatic req_z(input logic wr, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_z.enmem = 1'b1;
        bus_z.wrmem = wr;
        bus_z.addr  = a;
        bus_z.wdata = d;
        @(negedge clk);
        bus_z.enmem = 1'b0;
        chk("z_ready_early", 32'(bus_z.ready), 32'd0);
        @(negedge clk);
        chk("z_ready", 32'(bus_z.ready), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus_a.enmem = 1'b0; bus_a.wrmem = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_z.enmem = 1'b0; bus_z.wrmem = 1'b0; bus_z.addr = '0; bus_z.wdata = '0;

        // Asynchronous reset mid-cycle: outputs clear before the next edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_ready",  32'(bus_a.ready),  32'd0);
        chk("rst_busy",   32'(bus_a.busy),   32'd0);
        chk("rst_rdata",  32'(bus_a.rdata),  32'd0);
        chk("rst_ntrans", 32'(bus_a.ntrans), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        req_a(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, "rd_0");
        req_a(1'b0, 4'hF, 8'h00, 8'h00, 1'b0, "rd_f");
        chk("ntrans_after_reads", 32'(bus_a.ntrans), 32'd2);

        // Write 0xA5 to addr 3: rdata must not move, then read it back.
        req_a(1'b1, 4'h3, 8'hA5, 8'h00, 1'b0, "wr_3");
        chk("ntrans_after_wr", 32'(bus_a.ntrans), 32'd3);
        req_a(1'b0, 4'h3, 8'h00, 8'hA5, 1'b0, "rd_3");
        chk("ntrans_after_rd", 32'(bus_a.ntrans), 32'd4);

        // Held read request: period 5 = three WAIT, one DONE, one IDLE.
        @(negedge clk);
        bus_a.enmem = 1'b1;
        bus_a.wrmem = 1'b0;
        bus_a.addr  = 4'h3;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("held_ready", 32'(bus_a.ready), ((k - 1) % 5 == 3) ? 32'd1 : 32'd0);
            chk("held_busy",  32'(bus_a.busy),  ((k - 1) % 5 == 4) ? 32'd0 : 32'd1);
            if ((k - 1) % 5 == 3) begin
                chk("held_rdata", 32'(bus_a.rdata), 32'hA5);
            end
        end
        bus_a.enmem = 1'b0;
        @(negedge clk);
        chk("held_stop_busy", 32'(bus_a.busy), 32'd0);
        chk("ntrans_after_held", 32'(bus_a.ntrans), 32'd7);

        // Inputs changed during WAIT are ignored; addr 7 stays unwritten.
        req_a(1'b0, 4'h3, 8'h00, 8'hA5, 1'b1, "scr_3");
        req_a(1'b0, 4'h7, 8'h00, 8'h00, 1'b0, "rd_7");
        chk("ntrans_after_scr", 32'(bus_a.ntrans), 32'd9);

        // Reset in the first WAIT cycle of a write drops it.
        @(negedge clk);
        bus_a.enmem = 1'b1;
        bus_a.wrmem = 1'b1;
        bus_a.addr  = 4'h5;
        bus_a.wdata = 8'h3C;
        @(negedge clk);
        bus_a.enmem = 1'b0;
        chk("mid_busy_before", 32'(bus_a.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_busy",   32'(bus_a.busy),   32'd0);
        chk("mid_ntrans", 32'(bus_a.ntrans), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mid_no_ready", 32'(bus_a.ready), 32'd0);
        end
        chk("mid_ntrans_after", 32'(bus_a.ntrans), 32'd0);
        req_a(1'b0, 4'h5, 8'h00, 8'h00, 1'b0, "rd_5");
        req_a(1'b0, 4'h3, 8'h00, 8'h00, 1'b0, "rd_3_cleared");
        chk("ntrans_after_mid", 32'(bus_a.ntrans), 32'd2);

        // Zero wait states and ntrans wrap.
        req_z(1'b1, 4'h2, 8'h11);
        chk("z_ntrans_1", 32'(bus_z.ntrans), 32'd1);
        req_z(1'b0, 4'h2, 8'h00);
        chk("z_rdata", 32'(bus_z.rdata), 32'h11);
        for (int t = 3; t <= 255; t++) begin
            req_z(1'b0, 4'(t), 8'h00);
        end
        chk("z_ntrans_255", 32'(bus_z.ntrans), 32'hFF);
        req_z(1'b0, 4'h0, 8'h00);
        chk("z_ntrans_256", 32'(bus_z.ntrans), 32'h00);
        req_z(1'b0, 4'h0, 8'h00);
        chk("z_ntrans_257", 32'(bus_z.ntrans), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
